// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Sits between two bus masters (m0 = instruction fetch, m1 = load/store) and
// four targets (IMEM, DMEM, IO, SDRAM).
//
// The block handles one transaction at a time:
//   - Round-robin arbitration when both masters request in the same cycle.
//   - The target is decoded from addr[31:28].
//   - The request is issued to that target with a valid/ready handshake.
//   - The block then waits for the target's response strobe.
//   - It returns a single-cycle response (rdata / err) to the granted master.
//
// An unmapped address, or a target that does not respond within
// TIMEOUT_CYCLES, produces an error response so that a master can never
// stall forever.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mN_req_valid / mN_req_ready  request handshake (ready is combinational,
//                                IDLE only)
//   mN_addr/we/wdata/be          request fields
//   mN_rsp_valid/rdata/err       registered one-cycle response
//   s_valid[3:0]                 one-hot target request (IMEM, DMEM, IO, SDRAM)
//   s_ready[3:0]                 per-target request accept
//   s_addr/wdata/we/be           shared registered request fields
//   s_rsp_valid[3:0]             per-target response strobe
//   s_rdata[4*XLEN-1:0]          per-target read data, target k at [k*XLEN +: XLEN]
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [XLEN-1:0]   m0_addr,
    input  logic              m0_we,
    input  logic [XLEN-1:0]   m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_rsp_valid,
    output logic [XLEN-1:0]   m0_rdata,
    output logic              m0_err,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [XLEN-1:0]   m1_addr,
    input  logic              m1_we,
    input  logic [XLEN-1:0]   m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_rsp_valid,
    output logic [XLEN-1:0]   m1_rdata,
    output logic              m1_err,

    output logic [3:0]        s_valid,
    input  logic [3:0]        s_ready,
    output logic [XLEN-1:0]   s_addr,
    output logic [XLEN-1:0]   s_wdata,
    output logic              s_we,
    output logic [3:0]        s_be,
    input  logic [3:0]        s_rsp_valid,
    input  logic [4*XLEN-1:0] s_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic                   last_grant_reg;   // 0 = m0 granted last, 1 = m1
    logic                   grant_reg;        // master owning the transaction
    logic [1:0]             target_reg;       // decoded target index
    logic                   we_reg;
    logic [15:0]            timeout_cnt_reg;

    logic [3:0]             s_valid_reg;
    logic [XLEN-1:0]        s_addr_reg;
    logic [XLEN-1:0]        s_wdata_reg;
    logic                   s_we_reg;
    logic [3:0]             s_be_reg;

    // Per-master response registers, indexed by master number
    logic [1:0]             rsp_valid_reg;
    logic [1:0]             rsp_err_reg;
    logic [1:0][XLEN-1:0]   rsp_rdata_reg;

    // ------------------------------------------------------------------
    // Target read data unpacked into one word per target
    // ------------------------------------------------------------------
    logic [XLEN-1:0] s_rdata_arr [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rdata_slice
            assign s_rdata_arr[gi] = s_rdata[gi*XLEN +: XLEN];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0] req_valid_vec;
    logic [1:0] req_ready_vec;
    logic       grant_sel;
    logic       accept;

    assign req_valid_vec = {m1_req_valid, m0_req_valid};

    // On a tie, the master that was not granted last wins.
    always_comb begin
        grant_sel = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            grant_sel = ~last_grant_reg;
        end else if (m1_req_valid) begin
            grant_sel = 1'b1;
        end
    end

    // Accept only in IDLE, and never while reset is asserted, so that every
    // output reads 0 during reset.
    assign accept = (state_reg == ST_IDLE) && !rst && (|req_valid_vec);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready_vec[gi] = accept && (grant_sel == gi[0]);
        end
    endgenerate

    assign m0_req_ready = req_ready_vec[0];
    assign m1_req_ready = req_ready_vec[1];

    // Request fields of the master being granted this cycle
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic            sel_we;
    logic [3:0]      sel_be;

    always_comb begin
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_we    = m0_we;
        sel_be    = m0_be;
        if (grant_sel) begin
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_we    = m1_we;
            sel_be    = m1_be;
        end
    end

    // ------------------------------------------------------------------
    // Address decode on the top nibble
    // ------------------------------------------------------------------
    logic       sel_hit;
    logic [1:0] sel_target;

    always_comb begin
        sel_hit    = 1'b1;
        sel_target = 2'd0;
        case (sel_addr[XLEN-1:XLEN-4])
            4'h0:    sel_target = 2'd0;   // IMEM
            4'h2:    sel_target = 2'd1;   // DMEM
            4'h4:    sel_target = 2'd2;   // IO
            4'h6:    sel_target = 2'd3;   // SDRAM
            default: sel_hit    = 1'b0;   // unmapped
        endcase
    end

    // ------------------------------------------------------------------
    // Strobes from the selected target only; other targets are ignored
    // ------------------------------------------------------------------
    logic            tgt_ready;
    logic            tgt_rsp;
    logic [XLEN-1:0] tgt_rdata;
    logic            timeout_hit;

    assign tgt_ready   = s_ready[target_reg];
    assign tgt_rsp     = s_rsp_valid[target_reg];
    assign tgt_rdata   = s_rdata_arr[target_reg];
    assign timeout_hit = (timeout_cnt_reg == TIMEOUT_LIM);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            last_grant_reg  <= 1'b0;
            grant_reg       <= 1'b0;
            target_reg      <= 2'd0;
            we_reg          <= 1'b0;
            timeout_cnt_reg <= '0;
            s_valid_reg     <= '0;
            s_addr_reg      <= '0;
            s_wdata_reg     <= '0;
            s_we_reg        <= 1'b0;
            s_be_reg        <= '0;
            rsp_valid_reg   <= '0;
            rsp_err_reg     <= '0;
            rsp_rdata_reg   <= '0;
        end else begin
            // Responses are single-cycle strobes; clear them unless a branch
            // below raises one for the coming cycle.
            rsp_valid_reg <= '0;
            rsp_err_reg   <= '0;
            rsp_rdata_reg <= '0;

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant_reg <= grant_sel;
                        grant_reg      <= grant_sel;
                        target_reg     <= sel_target;
                        we_reg         <= sel_we;
                        s_addr_reg     <= sel_addr;
                        s_wdata_reg    <= sel_wdata;
                        s_we_reg       <= sel_we;
                        s_be_reg       <= sel_be;
                        if (!sel_hit) begin
                            // Unmapped: answer with an error and never touch a target
                            rsp_valid_reg[grant_sel] <= 1'b1;
                            rsp_err_reg[grant_sel]   <= 1'b1;
                            state_reg                <= ST_RESP;
                        end else begin
                            s_valid_reg     <= 4'b0001 << sel_target;
                            timeout_cnt_reg <= '0;
                            state_reg       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (tgt_ready && tgt_rsp) begin
                        // Zero-wait target: accepted and answered together
                        s_valid_reg               <= '0;
                        rsp_valid_reg[grant_reg]  <= 1'b1;
                        rsp_rdata_reg[grant_reg]  <= we_reg ? '0 : tgt_rdata;
                        state_reg                 <= ST_RESP;
                    end else if (timeout_hit) begin
                        s_valid_reg               <= '0;
                        rsp_valid_reg[grant_reg]  <= 1'b1;
                        rsp_err_reg[grant_reg]    <= 1'b1;
                        state_reg                 <= ST_RESP;
                    end else if (tgt_ready) begin
                        s_valid_reg     <= '0;
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                        state_reg       <= ST_WAIT;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
                end

                ST_WAIT: begin
                    // A response arriving on the timeout cycle still wins
                    if (tgt_rsp) begin
                        rsp_valid_reg[grant_reg]  <= 1'b1;
                        rsp_rdata_reg[grant_reg]  <= we_reg ? '0 : tgt_rdata;
                        state_reg                 <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_valid_reg[grant_reg]  <= 1'b1;
                        rsp_err_reg[grant_reg]    <= 1'b1;
                        state_reg                 <= ST_RESP;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
                end

                ST_RESP: begin
                    // The strobe raised on entry is cleared by the defaults above
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_valid      = s_valid_reg;
    assign s_addr       = s_addr_reg;
    assign s_wdata      = s_wdata_reg;
    assign s_we         = s_we_reg;
    assign s_be         = s_be_reg;

    assign m0_rsp_valid = rsp_valid_reg[0];
    assign m0_err       = rsp_err_reg[0];
    assign m0_rdata     = rsp_rdata_reg[0];
    assign m1_rsp_valid = rsp_valid_reg[1];
    assign m1_err       = rsp_err_reg[1];
    assign m1_rdata     = rsp_rdata_reg[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for mem_bus_arbiter. The DUT is instantiated with a short
// timeout (8). Inputs are driven on the falling edge, and outputs are checked
// 1 ns later, mid-cycle.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst;

    logic              m0_req_valid, m0_req_ready, m0_we, m0_rsp_valid, m0_err;
    logic [XLEN-1:0]   m0_addr, m0_wdata, m0_rdata;
    logic [3:0]        m0_be;
    logic              m1_req_valid, m1_req_ready, m1_we, m1_rsp_valid, m1_err;
    logic [XLEN-1:0]   m1_addr, m1_wdata, m1_rdata;
    logic [3:0]        m1_be;

    logic [3:0]        s_valid, s_ready, s_be, s_rsp_valid;
    logic [XLEN-1:0]   s_addr, s_wdata;
    logic              s_we;
    logic [4*XLEN-1:0] s_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_addr      (m0_addr),
        .m0_we        (m0_we),
        .m0_wdata     (m0_wdata),
        .m0_be        (m0_be),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rdata     (m0_rdata),
        .m0_err       (m0_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_addr      (m1_addr),
        .m1_we        (m1_we),
        .m1_wdata     (m1_wdata),
        .m1_be        (m1_be),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rdata     (m1_rdata),
        .m1_err       (m1_err),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_we         (s_we),
        .s_be         (s_be),
        .s_rsp_valid  (s_rsp_valid),
        .s_rdata      (s_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (middle of the next cycle)
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_targets();
        s_ready     = 4'b0000;
        s_rsp_valid = 4'b0000;
        s_rdata     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m0_req_ready"}, {31'd0, m0_req_ready}, 32'd0);
        check({tag, " m1_req_ready"}, {31'd0, m1_req_ready}, 32'd0);
        check({tag, " m0_rsp_valid"}, {31'd0, m0_rsp_valid}, 32'd0);
        check({tag, " m1_rsp_valid"}, {31'd0, m1_rsp_valid}, 32'd0);
        check({tag, " m0_rdata"}, m0_rdata, 32'd0);
        check({tag, " m1_rdata"}, m1_rdata, 32'd0);
        check({tag, " m0_err"}, {31'd0, m0_err}, 32'd0);
        check({tag, " m1_err"}, {31'd0, m1_err}, 32'd0);
        check({tag, " s_valid"}, {28'd0, s_valid}, 32'd0);
        check({tag, " s_addr"}, s_addr, 32'd0);
        check({tag, " s_wdata"}, s_wdata, 32'd0);
        check({tag, " s_we"}, {31'd0, s_we}, 32'd0);
        check({tag, " s_be"}, {28'd0, s_be}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req_valid = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0; m0_be = '0;
        m1_req_valid = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0; m1_be = '0;
        clear_targets();

        // ---------------- Reset state ----------------
        step(); step();
        m0_req_valid = 1'b1;            // must not be accepted while in reset
        settle();
        check_all_zero("reset");
        m0_req_valid = 1'b0;

        // ---------------- m0 read from IMEM, zero-wait target ----------------
        step();
        rst = 1'b0;
        m0_req_valid = 1'b1; m0_addr = 32'h0000_0010; m0_we = 1'b0; m0_be = 4'hF;
        settle();
        check("t1 m0_req_ready", {31'd0, m0_req_ready}, 32'd1);
        check("t1 m1_req_ready", {31'd0, m1_req_ready}, 32'd0);
        step();                                          // T+1
        m0_req_valid = 1'b0;
        s_ready = 4'b0001; s_rsp_valid = 4'b0001; s_rdata[0 +: 32] = 32'hDEAD_BEEF;
        settle();
        check("t1 s_valid", {28'd0, s_valid}, 32'h1);
        check("t1 s_addr", s_addr, 32'h0000_0010);
        check("t1 rsp_early", {31'd0, m0_rsp_valid}, 32'd0);
        step();                                          // T+2
        clear_targets();
        settle();
        check("t1 m0_rsp_valid", {31'd0, m0_rsp_valid}, 32'd1);
        check("t1 m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t1 m0_err", {31'd0, m0_err}, 32'd0);
        check("t1 s_valid_drop", {28'd0, s_valid}, 32'd0);
        check("t1 m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd0);
        step();                                          // T+3
        settle();
        check("t1 rsp_one_cycle", {31'd0, m0_rsp_valid}, 32'd0);

        // ---------------- Round-robin: both masters valid ----------------
        m0_addr = 32'h2000_0000; m1_addr = 32'h4000_0004; m1_we = 1'b0; m1_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            // m1 wins the first tie, then the grant alternates
            logic exp_m1;
            exp_m1 = (k % 2 == 0);
            step();
            m0_req_valid = 1'b1; m1_req_valid = 1'b1;
            settle();
            check($sformatf("rr%0d m0_req_ready", k), {31'd0, m0_req_ready}, {31'd0, !exp_m1});
            check($sformatf("rr%0d m1_req_ready", k), {31'd0, m1_req_ready}, {31'd0, exp_m1});
            step();
            s_ready     = exp_m1 ? 4'b0100 : 4'b0010;
            s_rsp_valid = s_ready;
            s_rdata     = '0;
            s_rdata[(exp_m1 ? 2 : 1)*32 +: 32] = 32'hA000_0000 + k;
            settle();
            check($sformatf("rr%0d s_valid", k), {28'd0, s_valid}, exp_m1 ? 32'h4 : 32'h2);
            check($sformatf("rr%0d s_addr", k), s_addr, exp_m1 ? 32'h4000_0004 : 32'h2000_0000);
            check($sformatf("rr%0d ready_busy", k), {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
            step();
            clear_targets();
            settle();
            check($sformatf("rr%0d m0_rsp_valid", k), {31'd0, m0_rsp_valid}, {31'd0, !exp_m1});
            check($sformatf("rr%0d m1_rsp_valid", k), {31'd0, m1_rsp_valid}, {31'd0, exp_m1});
            check($sformatf("rr%0d rdata", k), exp_m1 ? m1_rdata : m0_rdata, 32'hA000_0000 + k);
        end
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;

        // ---------------- m1 write to unmapped address ----------------
        step();
        m1_req_valid = 1'b1; m1_addr = 32'h1000_0000; m1_we = 1'b1; m1_wdata = 32'h5555_AAAA;
        settle();
        check("t3 m1_req_ready", {31'd0, m1_req_ready}, 32'd1);
        step();                                          // T+1
        m1_req_valid = 1'b0;
        settle();
        check("t3 m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd1);
        check("t3 m1_err", {31'd0, m1_err}, 32'd1);
        check("t3 m1_rdata", m1_rdata, 32'd0);
        check("t3 s_valid", {28'd0, s_valid}, 32'd0);
        step();
        settle();
        check("t3 rsp_drop", {31'd0, m1_rsp_valid}, 32'd0);

        // ---------------- SDRAM accepts but never answers ----------------
        step();
        m1_req_valid = 1'b1; m1_addr = 32'h6000_0000; m1_we = 1'b0;
        settle();
        check("t4 m1_req_ready", {31'd0, m1_req_ready}, 32'd1);
        step();                                          // ISSUE entry (E)
        m1_req_valid = 1'b0;
        s_ready = 4'b1000;
        settle();
        check("t4 s_valid", {28'd0, s_valid}, 32'h8);
        for (int c = 1; c <= 8; c++) begin
            step();
            clear_targets();
            settle();
            check($sformatf("t4 no_rsp E+%0d", c), {31'd0, m1_rsp_valid}, 32'd0);
            check($sformatf("t4 s_valid_low E+%0d", c), {28'd0, s_valid}, 32'd0);
        end
        step();                                          // E+9
        settle();
        check("t4 m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd1);
        check("t4 m1_err", {31'd0, m1_err}, 32'd1);
        check("t4 m1_rdata", m1_rdata, 32'd0);
        check("t4 s_valid_after", {28'd0, s_valid}, 32'd0);
        step();
        settle();
        check("t4 rsp_drop", {31'd0, m1_rsp_valid}, 32'd0);

        // ---------------- DMEM write with a 3-cycle s_ready stall ----------------
        step();
        m0_req_valid = 1'b1; m0_addr = 32'h2000_0008; m0_we = 1'b1;
        m0_wdata = 32'h1234_5678; m0_be = 4'b0101;
        settle();
        check("t5 m0_req_ready", {31'd0, m0_req_ready}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            step();
            m0_req_valid = 1'b0;
            s_ready = 4'b0100; s_rsp_valid = 4'b0100;    // IO strobes must be ignored
            s_rdata[2*32 +: 32] = 32'hBAD0_BAD0;
            settle();
            check($sformatf("t5 s_valid c%0d", c), {28'd0, s_valid}, 32'h2);
            check($sformatf("t5 s_addr c%0d", c), s_addr, 32'h2000_0008);
            check($sformatf("t5 s_wdata c%0d", c), s_wdata, 32'h1234_5678);
            check($sformatf("t5 s_be c%0d", c), {28'd0, s_be}, 32'h5);
            check($sformatf("t5 s_we c%0d", c), {31'd0, s_we}, 32'd1);
            check($sformatf("t5 no_rsp c%0d", c), {31'd0, m0_rsp_valid}, 32'd0);
        end
        step();                                          // T+4: DMEM accepts
        clear_targets();
        s_ready = 4'b0010;
        settle();
        check("t5 s_valid_accept", {28'd0, s_valid}, 32'h2);
        check("t5 no_rsp_accept", {31'd0, m0_rsp_valid}, 32'd0);
        step();                                          // T+5: WAIT
        clear_targets();
        s_rsp_valid = 4'b0010; s_rdata[1*32 +: 32] = 32'hFFFF_FFFF;
        settle();
        check("t5 s_valid_wait", {28'd0, s_valid}, 32'd0);
        step();                                          // T+6
        clear_targets();
        settle();
        check("t5 m0_rsp_valid", {31'd0, m0_rsp_valid}, 32'd1);
        check("t5 m0_err", {31'd0, m0_err}, 32'd0);
        check("t5 m0_rdata", m0_rdata, 32'd0);

        // ---------------- Reset while waiting on IO ----------------
        step();                                          // RESP -> IDLE
        step();
        m0_req_valid = 1'b1; m0_addr = 32'h4000_0000; m0_we = 1'b0; m0_be = 4'hF;
        settle();
        check("t6 m0_req_ready", {31'd0, m0_req_ready}, 32'd1);
        step();                                          // ISSUE
        m0_req_valid = 1'b0;
        s_ready = 4'b0100;
        settle();
        check("t6 s_valid", {28'd0, s_valid}, 32'h4);
        step();                                          // WAIT
        clear_targets();
        rst = 1'b1;
        settle();
        step();
        settle();
        check_all_zero("t6 after_rst");
        rst = 1'b0;
        s_rsp_valid = 4'b0100; s_rdata[2*32 +: 32] = 32'h0BAD_F00D;   // late answer
        m0_req_valid = 1'b1; m0_addr = 32'h0000_0020;
        settle();
        check("t6 new_req_ready", {31'd0, m0_req_ready}, 32'd1);
        step();
        m0_req_valid = 1'b0;
        clear_targets();
        s_ready = 4'b0001; s_rsp_valid = 4'b0001; s_rdata[0 +: 32] = 32'hCAFE_F00D;
        settle();
        check("t6 late_rsp_ignored", {31'd0, m0_rsp_valid}, 32'd0);
        check("t6 new_s_valid", {28'd0, s_valid}, 32'h1);
        step();
        clear_targets();
        settle();
        check("t6 new_rsp_valid", {31'd0, m0_rsp_valid}, 32'd1);
        check("t6 new_rdata", m0_rdata, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
